// File: rtl/ram_req_ctrl_if.sv
// Command/response channel bundle between a requester and ram_req_ctrl.
// The master modport is the requester side; the slave modport is the controller side.
interface ram_req_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_addr
    );
endinterface

// File: rtl/ram_req_ctrl.sv
// Serialising command front-end for a 16x8 single-port ram: one write or read
// in flight at a time, read data returned over a valid/ready response channel.
module ram_req_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    ram_req_ctrl_if.slave     bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            next_state_s;
    logic              cmd_fire_s;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic [ADDR_W-1:0] rsp_addr_r;

    // cmd fields are only looked at when a handshake happens, so X on them while idle stays contained
    assign cmd_fire_s    = bus.cmd_valid && (state_r == IDLE);
    assign bus.cmd_ready = (state_r == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_addr  = rsp_addr_r;
    assign busy          = (state_r != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    if (bus.cmd_we) begin
                        next_state_s = WR;
                    end else begin
                        next_state_s = RD_ADDR;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR:      next_state_s = IDLE;
            RD_ADDR: next_state_s = RD_CAP;
            RD_CAP:  next_state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Ram pin drive, response capture and operation counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_addr_r  <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        ram_we   <= bus.cmd_we;
                        ram_addr <= bus.cmd_addr;
                        if (bus.cmd_we) begin
                            ram_data_in <= bus.cmd_wdata;
                        end
                    end
                end
                WR: begin
                    ram_we <= 1'b0;
                    wr_cnt <= wr_cnt + CNT_ONE;
                end
                RD_CAP: begin
                    // Two edges after the address was driven: valid for registered or combinational ram reads
                    rsp_rdata_r <= ram_data_out;
                    rsp_addr_r  <= ram_addr;
                    rsp_valid_r <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rd_cnt      <= rd_cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural 16x8 registered-read ram
// attached to the ram pins; vector table plus hand sequences for reset corners.
module tb_ram_req_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;
    logic       busy;
    logic [7:0] wr_cnt;
    logic [7:0] rd_cnt;
    logic [7:0] mem [16];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         hs_cyc = 0;
    int         hs_prev = 0;
    logic       prev_keep = 1'b0;
    logic [7:0] exp_wr = 8'd0;
    logic [7:0] exp_rd = 8'd0;

    ram_req_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_req_ctrl #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy),
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    typedef struct {
        logic       is_rd;
        logic [3:0] addr;
        logic [7:0] data;
        int         hold;
        logic       keep;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drop_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'bx;
        bus.cmd_addr  = 4'bxxxx;
        bus.cmd_wdata = 8'bxxxxxxxx;
    endtask

    // Present a command, wait (bounded) for ready, advance through the handshake edge
    task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int n = 0; n < 50 && !bus.cmd_ready; n++) step();
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        step();
        hs_prev = hs_cyc;
        hs_cyc  = cyc;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic keep);
        issue(1'b1, a, d);
        if (prev_keep) chk("wr_accept_gap", hs_cyc - hs_prev, 2);
        chk("wr_ram_we_hi", ram_we, 1);
        chk("wr_ram_addr", ram_addr, a);
        chk("wr_ram_data", ram_data_in, d);
        chk("wr_busy", busy, 1);
        chk("wr_cmd_ready_lo", bus.cmd_ready, 0);
        step();
        exp_wr = exp_wr + 8'd1;
        chk("wr_ram_we_lo", ram_we, 0);
        chk("wr_cnt", wr_cnt, exp_wr);
        chk("wr_addr_hold", ram_addr, a);
        chk("wr_idle_ready", bus.cmd_ready, 1);
        prev_keep = keep;
        if (!keep) drop_cmd();
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int hold);
        bus.rsp_ready = (hold == 0);
        issue(1'b0, a, 8'h00);
        drop_cmd();
        prev_keep = 1'b0;
        chk("rd_valid_n", bus.rsp_valid, 0);
        chk("rd_busy", busy, 1);
        chk("rd_ram_we", ram_we, 0);
        step();
        chk("rd_valid_n1", bus.rsp_valid, 0);
        step();
        chk("rd_valid_n2", bus.rsp_valid, 1);
        chk("rd_rdata", bus.rsp_rdata, exp);
        chk("rd_raddr", bus.rsp_addr, a);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("rd_hold_valid", bus.rsp_valid, 1);
            chk("rd_hold_rdata", bus.rsp_rdata, exp);
            chk("rd_hold_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        exp_rd = exp_rd + 8'd1;
        chk("rd_release", bus.rsp_valid, 0);
        chk("rd_cnt", rd_cnt, exp_rd);
        chk("rd_idle_ready", bus.cmd_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_cnt"}, wr_cnt, 0);
        chk({tag, "_rd_cnt"}, rd_cnt, 0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'd1,  8'h0A, 0, 1'b1};
        vecs[1]  = '{1'b0, 4'd2,  8'h14, 0, 1'b1};
        vecs[2]  = '{1'b0, 4'd3,  8'h1E, 0, 1'b0};
        vecs[3]  = '{1'b1, 4'd1,  8'h0A, 0, 1'b0};
        vecs[4]  = '{1'b1, 4'd2,  8'h14, 0, 1'b0};
        vecs[5]  = '{1'b1, 4'd3,  8'h1E, 0, 1'b0};
        vecs[6]  = '{1'b1, 4'd2,  8'h14, 5, 1'b0};
        vecs[7]  = '{1'b0, 4'd15, 8'hFF, 0, 1'b0};
        vecs[8]  = '{1'b1, 4'd15, 8'hFF, 0, 1'b0};
        vecs[9]  = '{1'b0, 4'd0,  8'h5A, 0, 1'b0};
        vecs[10] = '{1'b1, 4'd0,  8'h5A, 1, 1'b0};

        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        drop_cmd();
        repeat (3) step();
        chk_reset_outputs("reset");
        chk("reset_rdata", bus.rsp_rdata, 0);
        chk("reset_raddr", bus.rsp_addr, 0);
        chk("reset_data_in", ram_data_in, 0);
        rst = 1'b0;
        step();
        chk("post_reset_ready", bus.cmd_ready, 1);
        chk("post_reset_busy", busy, 0);

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].is_rd) do_read(vecs[v].addr, vecs[v].data, vecs[v].hold);
            else               do_write(vecs[v].addr, vecs[v].data, vecs[v].keep);
        end
        chk("ram_word1", mem[1], 8'h0A);
        chk("ram_word2", mem[2], 8'h14);
        chk("ram_word3", mem[3], 8'h1E);

        // 5 writes done so far; 251 more lands the counter exactly on the wrap
        for (int i = 0; i < 251; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            do_write(iv[3:0], iv, 1'b1);
        end
        drop_cmd();
        prev_keep = 1'b0;
        chk("wr_cnt_wrap", wr_cnt, 0);

        // reset while the response is being held
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd2, 8'h00);
        drop_cmd();
        step();
        step();
        chk("resp_before_rst", bus.rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_in_resp");
        exp_wr = 8'd0;
        exp_rd = 8'd0;
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stray_rsp_a", bus.rsp_valid, 0);
        end

        // reset in RD_CAP
        issue(1'b0, 4'd3, 8'h00);
        drop_cmd();
        step();
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_in_rdcap");
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stray_rsp_b", bus.rsp_valid, 0);
            chk("idle_after_rdcap", busy, 0);
        end

        // reset in WR after one completed write
        do_write(4'd4, 8'h44, 1'b0);
        issue(1'b1, 4'd5, 8'h55);
        chk("wr_before_rst", ram_we, 1);
        rst = 1'b1;
        #1;
        drop_cmd();
        chk_reset_outputs("rst_in_wr");
        exp_wr = 8'd0;
        step();
        rst = 1'b0;
        step();
        chk("no_stray_rsp_c", bus.rsp_valid, 0);

        do_write(4'd1, 8'hA5, 1'b0);
        do_read(4'd1, 8'hA5, 0);
        do_read(4'd4, 8'h44, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
